// File: rtl/mem_access_unit_if.sv
// Bundles the controller handshake and the memory req/ack port of mem_access_unit.
// With MEM_BYTE_ACCESS_EN defined, adds the byte-select input and the byte-enable output.
interface mem_access_unit_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16
) ();
    logic              start_i;
    logic              mem_read_i;
    logic              mem_write_i;
    logic [ADDR_W-1:0] addr_i;
    logic [DATA_W-1:0] store_data_i;
    logic              mem_ack_i;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mdr_o;
    logic              busy_o;
    logic              done_o;
    logic              bus_err_o;
`ifdef MEM_BYTE_ACCESS_EN
    logic              byte_sel_i;
    logic [1:0]        mem_be_o;
`endif

    // Controller / memory side: drives requests and memory responses.
    modport master (
        output start_i, mem_read_i, mem_write_i, addr_i, store_data_i, mem_ack_i, mem_rdata_i,
`ifdef MEM_BYTE_ACCESS_EN
        output byte_sel_i,
        input  mem_be_o,
`endif
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mdr_o, busy_o, done_o, bus_err_o
    );

    // Access unit side.
    modport slave (
        input  start_i, mem_read_i, mem_write_i, addr_i, store_data_i, mem_ack_i, mem_rdata_i,
`ifdef MEM_BYTE_ACCESS_EN
        input  byte_sel_i,
        output mem_be_o,
`endif
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mdr_o, busy_o, done_o, bus_err_o
    );
endinterface

// File: rtl/mem_access_unit.sv
// Multicycle load/store stage: runs one req/ack memory transaction per Start,
// returns load data in the MDR, aborts with Bus_Err after TIMEOUT_CYCLES unacked cycles.
// Optional byte access is enabled by defining MEM_BYTE_ACCESS_EN.
module mem_access_unit #(
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input logic              clk_i,
    input logic              rst_ni,
    mem_access_unit_if.slave bus
);
    localparam int unsigned CNT_W  = 8;
`ifdef MEM_BYTE_ACCESS_EN
    localparam int unsigned HALF_W = DATA_W / 2;
`endif

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              bus_err_q, bus_err_d;
`ifdef MEM_BYTE_ACCESS_EN
    logic              byte_q, byte_d;
    logic [1:0]        mem_be_q, mem_be_d;
`endif

    // State and registered outputs; reset clears everything at once, even mid-access.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mdr_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            bus_err_q   <= 1'b0;
`ifdef MEM_BYTE_ACCESS_EN
            byte_q      <= 1'b0;
            mem_be_q    <= 2'b00;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mdr_q       <= mdr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            bus_err_q   <= bus_err_d;
`ifdef MEM_BYTE_ACCESS_EN
            byte_q      <= byte_d;
            mem_be_q    <= mem_be_d;
`endif
        end
    end

    // Next state and next registered outputs; outputs describe the state being entered.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mdr_d       = mdr_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        bus_err_d   = 1'b0;
`ifdef MEM_BYTE_ACCESS_EN
        byte_d      = byte_q;
        mem_be_d    = mem_be_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.start_i && (bus.mem_read_i ^ bus.mem_write_i)) begin
                    state_d     = REQ;
                    cnt_d       = '0;
                    mem_req_d   = 1'b1;
                    busy_d      = 1'b1;
                    mem_we_d    = bus.mem_write_i;
                    mem_addr_d  = bus.addr_i;
                    mem_wdata_d = bus.store_data_i;
`ifdef MEM_BYTE_ACCESS_EN
                    byte_d      = bus.byte_sel_i;
                    if (bus.byte_sel_i) begin
                        mem_be_d    = bus.addr_i[0] ? 2'b10 : 2'b01;
                        mem_wdata_d = {2{bus.store_data_i[HALF_W-1:0]}};
                    end else begin
                        mem_be_d    = 2'b11;
                    end
`endif
                end else if (bus.start_i && bus.mem_read_i && bus.mem_write_i) begin
                    // Conflicting direction: report an error without touching the memory port.
                    state_d   = DONE;
                    busy_d    = 1'b1;
                    done_d    = 1'b1;
                    bus_err_d = 1'b1;
                end
            end
            REQ: begin
                busy_d = 1'b1;
                if (bus.mem_ack_i) begin
                    // Ack beats a coincident timeout expiry.
                    state_d = DONE;
                    done_d  = 1'b1;
                    if (!mem_we_q) begin
                        mdr_d = bus.mem_rdata_i;
`ifdef MEM_BYTE_ACCESS_EN
                        if (byte_q) begin
                            mdr_d = mem_addr_q[0] ? DATA_W'(bus.mem_rdata_i[DATA_W-1:HALF_W])
                                                  : DATA_W'(bus.mem_rdata_i[HALF_W-1:0]);
                        end
`endif
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d     = cnt_q + CNT_W'(1);
                    mem_req_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.mem_req_o   = mem_req_q;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;
    assign bus.mdr_o       = mdr_q;
    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.bus_err_o   = bus_err_q;
`ifdef MEM_BYTE_ACCESS_EN
    assign bus.mem_be_o    = mem_be_q;
`endif
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit; byte-access scenarios run when MEM_BYTE_ACCESS_EN is defined.
module tb_mem_access_unit;
    logic clk;
    logic rst_n;

    mem_access_unit_if #(.DATA_W(16), .ADDR_W(16)) bus ();

    mem_access_unit #(.DATA_W(16), .ADDR_W(16), .TIMEOUT_CYCLES(15)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    typedef struct {
        logic        err;
        logic [15:0] mdr;
        int          reqs;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   req_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: on every Done pulse pop the expected outcome and compare.
    always @(negedge clk) begin
        if (!rst_n) begin
            req_cnt = 0;
        end else begin
            if (bus.mem_req_o) req_cnt++;
            if (bus.done_o) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected_done: Done seen with no access outstanding at %0t", $time);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (bus.bus_err_o !== e.err || bus.mdr_o !== e.mdr || req_cnt != e.reqs ||
                        bus.busy_o !== 1'b1) begin
                        n_fail++;
                        $display("FAIL sb_done: got err=%b mdr=%h reqs=%0d busy=%b, want err=%b mdr=%h reqs=%0d busy=1",
                                 bus.bus_err_o, bus.mdr_o, req_cnt, bus.busy_o, e.err, e.mdr, e.reqs);
                    end
                end
                req_cnt = 0;
            end
        end
    end

    task automatic push_exp(input logic err, input logic [15:0] mdr, input int reqs);
        exp_t e;
        e.err = err; e.mdr = mdr; e.reqs = reqs;
        sb.push_back(e);
    endtask

    // Drives a one-cycle Start; returns #1 after the edge that sampled it.
    task automatic pulse_start(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
        bus.start_i      = 1'b1;
        bus.mem_read_i   = rd;
        bus.mem_write_i  = wr;
        bus.addr_i       = a;
        bus.store_data_i = d;
        @(posedge clk); #1;
        bus.start_i      = 1'b0;
        bus.mem_read_i   = 1'b0;
        bus.mem_write_i  = 1'b0;
        bus.addr_i       = 16'(~a);
        bus.store_data_i = 16'(~d);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step();
        n_tests++;
        if (bus.mem_req_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.bus_err_o !== 1'b0 ||
            bus.mdr_o !== 16'h0 || bus.mem_we_o !== 1'b0 || bus.mem_addr_o !== 16'h0 || bus.mem_wdata_o !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_state: req=%b busy=%b done=%b err=%b mdr=%h we=%b addr=%h wdata=%h, want all 0",
                     bus.mem_req_o, bus.busy_o, bus.done_o, bus.bus_err_o, bus.mdr_o, bus.mem_we_o,
                     bus.mem_addr_o, bus.mem_wdata_o);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_load_immediate();
        push_exp(1'b0, 16'hBEEF, 1);
        pulse_start(1'b1, 1'b0, 16'h0040, 16'h0000);
        n_tests++;
        if (bus.mem_req_o !== 1'b1 || bus.mem_we_o !== 1'b0 || bus.mem_addr_o !== 16'h0040 || bus.busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL load_req: req=%b we=%b addr=%h busy=%b, want 1 0 0040 1",
                     bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.busy_o);
        end
`ifdef MEM_BYTE_ACCESS_EN
        n_tests++;
        if (bus.mem_be_o !== 2'b11) begin
            n_fail++;
            $display("FAIL word_be: got %b want 11", bus.mem_be_o);
        end
`endif
        bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 16'hBEEF;
        step();
        bus.mem_ack_i = 1'b0; bus.mem_rdata_i = 16'h0000;
        n_tests++;
        if (bus.done_o !== 1'b1 || bus.mdr_o !== 16'hBEEF || bus.mem_req_o !== 1'b0 || bus.bus_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL load_done: done=%b mdr=%h req=%b err=%b, want 1 BEEF 0 0",
                     bus.done_o, bus.mdr_o, bus.mem_req_o, bus.bus_err_o);
        end
        step();
        n_tests++;
        if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL load_idle: done=%b busy=%b, want 0 0", bus.done_o, bus.busy_o);
        end
    endtask

    task automatic test_store_wait();
        push_exp(1'b0, 16'hBEEF, 4);
        pulse_start(1'b0, 1'b1, 16'h1234, 16'hA5A5);
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (bus.mem_req_o !== 1'b1 || bus.mem_we_o !== 1'b1 || bus.mem_addr_o !== 16'h1234 ||
                bus.mem_wdata_o !== 16'hA5A5 || bus.done_o !== 1'b0) begin
                n_fail++;
                $display("FAIL store_hold[%0d]: req=%b we=%b addr=%h wdata=%h done=%b, want 1 1 1234 A5A5 0",
                         i, bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.done_o);
            end
            if (i == 3) begin
                bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 16'hDEAD;
            end
            step();
        end
        bus.mem_ack_i = 1'b0;
        n_tests++;
        if (bus.done_o !== 1'b1 || bus.mdr_o !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL store_done: done=%b mdr=%h, want 1 BEEF", bus.done_o, bus.mdr_o);
        end
        step();
        n_tests++;
        if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL store_single_done: done=%b busy=%b, want 0 0", bus.done_o, bus.busy_o);
        end
    endtask

    task automatic test_timeout();
        int n;
        push_exp(1'b1, 16'hBEEF, 15);
        pulse_start(1'b1, 1'b0, 16'h0080, 16'h0000);
        n = 0;
        for (int i = 0; i < 40 && bus.done_o !== 1'b1; i++) begin
            if (bus.mem_req_o === 1'b1) n++;
            step();
        end
        n_tests++;
        if (bus.done_o !== 1'b1 || bus.bus_err_o !== 1'b1 || n != 15 || bus.mdr_o !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL timeout: done=%b err=%b req_cycles=%0d mdr=%h, want 1 1 15 BEEF",
                     bus.done_o, bus.bus_err_o, n, bus.mdr_o);
        end
        step();
        n_tests++;
        if (bus.done_o !== 1'b0 || bus.bus_err_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_pulse: done=%b err=%b busy=%b, want 0 0 0", bus.done_o, bus.bus_err_o, bus.busy_o);
        end
    endtask

    task automatic test_illegal();
        push_exp(1'b1, 16'hBEEF, 0);
        pulse_start(1'b1, 1'b1, 16'h0010, 16'h0000);
        n_tests++;
        if (bus.mem_req_o !== 1'b0 || bus.done_o !== 1'b1 || bus.bus_err_o !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_start: req=%b done=%b err=%b, want 0 1 1", bus.mem_req_o, bus.done_o, bus.bus_err_o);
        end
        step();
        // Neither direction set: Start must be ignored.
        pulse_start(1'b0, 1'b0, 16'h0020, 16'h0000);
        n_tests++;
        if (bus.mem_req_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL null_start: req=%b busy=%b done=%b, want 0 0 0", bus.mem_req_o, bus.busy_o, bus.done_o);
        end
    endtask

    task automatic test_start_while_busy();
        push_exp(1'b0, 16'h1111, 2);
        pulse_start(1'b1, 1'b0, 16'h0100, 16'h0000);
        pulse_start(1'b0, 1'b1, 16'h0200, 16'h7777);
        n_tests++;
        if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 16'h0100 || bus.mem_we_o !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_start_ignored: req=%b addr=%h we=%b, want 1 0100 0",
                     bus.mem_req_o, bus.mem_addr_o, bus.mem_we_o);
        end
        bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 16'h1111;
        step();
        bus.mem_ack_i = 1'b0;
        // Start during DONE is also ignored.
        pulse_start(1'b1, 1'b0, 16'h0500, 16'h0000);
        n_tests++;
        if (bus.mem_req_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.mdr_o !== 16'h1111) begin
            n_fail++;
            $display("FAIL done_start_ignored: req=%b busy=%b mdr=%h, want 0 0 1111",
                     bus.mem_req_o, bus.busy_o, bus.mdr_o);
        end
    endtask

    task automatic test_stray_ack();
        bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 16'h5555;
        step(); step();
        bus.mem_ack_i = 1'b0; bus.mem_rdata_i = 16'h0000;
        n_tests++;
        if (bus.mdr_o !== 16'h1111 || bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_ack: mdr=%h done=%b busy=%b, want 1111 0 0", bus.mdr_o, bus.done_o, bus.busy_o);
        end
    endtask

    task automatic test_reset_mid();
        pulse_start(1'b1, 1'b0, 16'h0300, 16'h0000);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.mem_req_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.mdr_o !== 16'h0) begin
            n_fail++;
            $display("FAIL async_reset: req=%b busy=%b mdr=%h, want 0 0 0000", bus.mem_req_o, bus.busy_o, bus.mdr_o);
        end
        sb.delete();
        step();
        rst_n = 1'b1;
        step();
        push_exp(1'b0, 16'hCAFE, 1);
        pulse_start(1'b1, 1'b0, 16'h0302, 16'h0000);
        bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 16'hCAFE;
        step();
        bus.mem_ack_i = 1'b0;
        n_tests++;
        if (bus.done_o !== 1'b1 || bus.mdr_o !== 16'hCAFE || bus.mem_addr_o !== 16'h0302) begin
            n_fail++;
            $display("FAIL post_reset_load: done=%b mdr=%h addr=%h, want 1 CAFE 0302",
                     bus.done_o, bus.mdr_o, bus.mem_addr_o);
        end
        step();
    endtask

`ifdef MEM_BYTE_ACCESS_EN
    task automatic test_byte();
        push_exp(1'b0, 16'h0012, 1);
        bus.byte_sel_i = 1'b1;
        pulse_start(1'b1, 1'b0, 16'h0041, 16'h0000);
        n_tests++;
        if (bus.mem_be_o !== 2'b10) begin
            n_fail++;
            $display("FAIL byte_load_be: got %b want 10", bus.mem_be_o);
        end
        bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 16'h12F0;
        step();
        bus.mem_ack_i = 1'b0;
        n_tests++;
        if (bus.mdr_o !== 16'h0012) begin
            n_fail++;
            $display("FAIL byte_load_mdr: got %h want 0012", bus.mdr_o);
        end
        step();
        push_exp(1'b0, 16'h0012, 1);
        pulse_start(1'b0, 1'b1, 16'h0040, 16'h00C3);
        bus.byte_sel_i = 1'b0;
        n_tests++;
        if (bus.mem_be_o !== 2'b01 || bus.mem_wdata_o !== 16'hC3C3 || bus.mem_we_o !== 1'b1) begin
            n_fail++;
            $display("FAIL byte_store: be=%b wdata=%h we=%b, want 01 C3C3 1", bus.mem_be_o, bus.mem_wdata_o, bus.mem_we_o);
        end
        bus.mem_ack_i = 1'b1;
        step();
        bus.mem_ack_i = 1'b0;
        step();
    endtask
`endif

    initial begin
        bus.start_i      = 1'b0;
        bus.mem_read_i   = 1'b0;
        bus.mem_write_i  = 1'b0;
        bus.addr_i       = 16'h0;
        bus.store_data_i = 16'h0;
        bus.mem_ack_i    = 1'b0;
        bus.mem_rdata_i  = 16'h0;
`ifdef MEM_BYTE_ACCESS_EN
        bus.byte_sel_i   = 1'b0;
`endif
        rst_n = 1'b0;
        #2;
        test_reset();
        test_load_immediate();
        test_store_wait();
        test_timeout();
        test_illegal();
        test_start_while_busy();
        test_stray_ack();
        test_reset_mid();
`ifdef MEM_BYTE_ACCESS_EN
        test_byte();
`endif
        step(); step();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d expected completions never seen, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Multicycle memory-access stage directly downstream of ALU_Subsystem.
- Takes the registered ALU_Out as the effective address and the B operand as store data.
- Runs one load or store transaction over a req/ack memory port and returns load data in an internal memory data register (MDR) for writeback.
- Controller asserts Start and stalls on Busy until Done.

Parameters:
- DATA_W, 16, data width of store, load and MDR paths.
- ADDR_W, 16, address width.
- TIMEOUT_CYCLES, 15, REQ cycles without Mem_Ack before abort; legal range 1..255.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  one-cycle request to begin an access; sampled only in IDLE.
- Mem_Read  input  1  access is a load.
- Mem_Write  input  1  access is a store.
- Addr  input  ADDR_W  effective address (ALU_Out).
- Store_Data  input  DATA_W  store data (B operand).
- Mem_Ack  input  1  memory completion strobe.
- Mem_RData  input  DATA_W  memory read data, valid with Mem_Ack.
- Mem_Req  output  1  request valid.
- Mem_WE  output  1  1 = write, 0 = read; valid while Mem_Req.
- Mem_Addr  output  ADDR_W  latched address.
- Mem_WData  output  DATA_W  latched store data.
- MDR  output  DATA_W  last successfully loaded data.
- Busy  output  1  access in progress (REQ or DONE).
- Done  output  1  one-cycle completion pulse.
- Bus_Err  output  1  one-cycle error pulse, coincident with Done.

Behaviour:
- Reset (Reset=0, asynchronous):
  - State goes to IDLE immediately, including mid-transaction.
  - All outputs go to 0 and MDR clears to 0.
  - Mem_Req drops without waiting for a clock.
- States: IDLE, REQ, DONE.
- IDLE:
  - Busy=0, Mem_Req=0.
  - On Start with exactly one of Mem_Read/Mem_Write set: latch Addr, Store_Data and direction; clear the timeout counter; go to REQ.
  - Start with neither set: ignored.
  - Start with both set: no request issued; go to DONE with Bus_Err=1.
- REQ:
  - Mem_Req=1; Mem_Addr, Mem_WE and Mem_WData stay stable until Mem_Ack is sampled high.
  - On Mem_Ack=1: for a load, MDR <= Mem_RData; for a store, MDR is unchanged. Go to DONE.
  - On no Mem_Ack: counter increments. When the counter reaches TIMEOUT_CYCLES-1 with no ack, go to DONE with Bus_Err=1 and leave MDR unchanged.
  - An ack arriving in the same cycle as timeout expiry wins: normal completion, no error.
- DONE:
  - Mem_Req=0, Done=1, Busy=1 for exactly one cycle, then IDLE.
  - Start during DONE is ignored; the controller must wait for Busy=0.
- Latency: Start sampled at edge 0 -> Mem_Req high after edge 0. Ack sampled at edge k -> Done high for the cycle after edge k. Minimum Start-to-Done is 2 cycles.
- Mem_Ack in IDLE or DONE is ignored; MDR does not change.
- Start while Busy is ignored; latched address and data are unaffected.
- MDR holds its value between accesses; an aborted load never corrupts it.
- Addr and Store_Data may change freely after the Start cycle.

Optional Feature:
- Macro: MEM_BYTE_ACCESS_EN.
- When defined:
  - Adds input Byte (1) and output Mem_BE (2).
  - Byte=0: word access with Mem_BE=2'b11.
  - Byte=1 store: Mem_BE=2'b01 if Addr[0]=0, else 2'b10; the low byte of Store_Data is replicated into both halves of Mem_WData.
  - Byte=1 load: MDR <= zero-extended selected byte, low byte when Addr[0]=0, high byte otherwise.
  - Byte and Addr[0] are latched at Start.
- When undefined:
  - Byte and Mem_BE ports do not exist.
  - All accesses are full-word, with behaviour exactly as described above.

Test Plan:
- Load, immediate ack: Addr=0x0040, Mem_Read=1, Start. Mem_RData=0xBEEF with Mem_Ack on the first REQ cycle -> Mem_Req high 1 cycle, Mem_WE=0, Done 2 cycles after Start, MDR=0xBEEF, Bus_Err=0.
- Store with 3 wait states: Addr=0x1234, Store_Data=0xA5A5, Mem_Write=1. Ack on the 4th REQ cycle -> Mem_Addr=0x1234, Mem_WData=0xA5A5 held 4 cycles, Mem_WE=1, MDR unchanged, single Done pulse.
- Timeout: TIMEOUT_CYCLES=15, load with no ack -> Mem_Req high exactly 15 cycles, then Done=Bus_Err=1 for 1 cycle. MDR retains the previous value 0xBEEF.
- Illegal and ignored starts:
  - Mem_Read=Mem_Write=1 -> no Mem_Req; Done=Bus_Err=1 the next cycle.
  - Start while Busy -> ignored; the original address is completed.
  - Stray Mem_Ack in IDLE -> MDR unchanged.
- Reset mid-access: Reset=0 in the 2nd REQ cycle, between clock edges -> Mem_Req, Busy and MDR go to 0 immediately. After release, a new load completes normally.
- MEM_BYTE_ACCESS_EN: byte load at Addr=0x0041 with Mem_RData=0x12F0 -> MDR=0x0012. Byte store of 0x00C3 at Addr=0x0040 -> Mem_BE=2'b01, Mem_WData=0xC3C3.
